combo_lock_fsm: RTL and testbench



---
 rtl/lock_pkg.sv | 11 +
 rtl/btn_edge.sv | 26 ++
 rtl/combo_lock_fsm.sv | 143 ++++++++++++++
 tb/tb_combo_lock_fsm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared encodings for the combination lock and its display decoder.
// State codes are part of the 3-bit interface to the decoder.
package lock_pkg;
  localparam int CODE_W = 4;

  localparam logic [2:0] ST_LOCKED = 3'b000;
  localparam logic [2:0] ST_RETRY  = 3'b001;
  localparam logic [2:0] ST_ALARM  = 3'b010;
  localparam logic [2:0] ST_NEW_PW = 3'b011;
  localparam logic [2:0] ST_OPEN   = 3'b100;
endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser followed by a rising-edge one-cycle pulse.
// All flops clear on asynchronous active-low reset.
module btn_edge (
  input  logic clk,
  input  logic resetn,
  input  logic i_btn,
  output logic o_pulse
);
  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;
endmodule

// File: rtl/combo_lock_fsm.sv
// Combination lock state machine driving the 3-bit display state code.
// Optional OPEN auto-relock timer enabled by defining AUTO_RELOCK_EN.
module combo_lock_fsm
  import lock_pkg::*;
#(
  parameter int                CODE_W       = lock_pkg::CODE_W,
  parameter logic [CODE_W-1:0] DEFAULT_PW   = 4'b1010,
  parameter logic [CODE_W-1:0] MASTER_PW    = 4'b1111,
  parameter int                MAX_TRIES    = 3,
  parameter int                OPEN_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CODE_W-1:0] code_in,
  input  logic              enter_btn,
  input  logic              change_btn,
  input  logic              lock_btn,
  output logic [2:0]        state,
  output logic              unlocked,
  output logic              alarm,
  output logic [2:0]        fail_cnt
);
  logic w_enter;
  logic w_change;
  logic w_lock;
  logic w_timeout;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [CODE_W-1:0] r_pw;
  logic [CODE_W-1:0] w_pw_nxt;
  logic [2:0]        r_fail;
  logic [2:0]        w_fail_nxt;
  logic [2:0]        w_fail_inc;

  btn_edge u_enter (
    .clk    (clk),
    .resetn (resetn),
    .i_btn  (enter_btn),
    .o_pulse(w_enter)
  );

  btn_edge u_change (
    .clk    (clk),
    .resetn (resetn),
    .i_btn  (change_btn),
    .o_pulse(w_change)
  );

  btn_edge u_lock (
    .clk    (clk),
    .resetn (resetn),
    .i_btn  (lock_btn),
    .o_pulse(w_lock)
  );

`ifdef AUTO_RELOCK_EN
  localparam int TW = $clog2(OPEN_TIMEOUT + 1);
  logic [TW-1:0] r_timer;

  // Zero whenever not OPEN, so every entry into OPEN starts from 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer <= '0;
    end else if (r_state != ST_OPEN) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_OPEN) &&
                     (r_timer == TW'(OPEN_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_LOCKED;
      r_pw    <= DEFAULT_PW;
      r_fail  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pw    <= w_pw_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  assign w_fail_inc = r_fail + 3'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_pw_nxt    = r_pw;
    w_fail_nxt  = r_fail;
    unique case (r_state)
      ST_LOCKED, ST_RETRY: begin
        if (w_enter) begin
          if (code_in == r_pw) begin
            w_state_nxt = ST_OPEN;
            w_fail_nxt  = 3'd0;
          end else begin
            w_fail_nxt  = w_fail_inc;
            w_state_nxt = (w_fail_inc == 3'(MAX_TRIES)) ?
                          ST_ALARM : ST_RETRY;
          end
        end
      end
      ST_OPEN: begin
        if (w_lock || w_timeout) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_change) begin
          w_state_nxt = ST_NEW_PW;
        end
      end
      ST_NEW_PW: begin
        if (w_lock) begin
          w_state_nxt = ST_LOCKED;
        end else if (w_enter) begin
          w_pw_nxt    = code_in;
          w_state_nxt = ST_OPEN;
        end
      end
      ST_ALARM: begin
        if (w_enter && (code_in == MASTER_PW)) begin
          w_state_nxt = ST_LOCKED;
          w_fail_nxt  = 3'd0;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKED;
        w_fail_nxt  = 3'd0;
      end
    endcase
  end

  always_comb begin
    state    = r_state;
    unlocked = (r_state == ST_OPEN);
    alarm    = (r_state == ST_ALARM);
    fail_cnt = r_fail;
  end
endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed self-checking bench for combo_lock_fsm.
// Build with AUTO_RELOCK_EN defined to exercise the relock timer.
module tb_combo_lock_fsm;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] code_in = 4'd0;
  logic       enter_btn = 1'b0;
  logic       change_btn = 1'b0;
  logic       lock_btn = 1'b0;
  logic [2:0] state;
  logic       unlocked;
  logic       alarm;
  logic [2:0] fail_cnt;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] LK = 3'b000;
  localparam logic [2:0] RT = 3'b001;
  localparam logic [2:0] AL = 3'b010;
  localparam logic [2:0] NP = 3'b011;
  localparam logic [2:0] OP = 3'b100;

  combo_lock_fsm #(
    .CODE_W      (4),
    .DEFAULT_PW  (4'b1010),
    .MASTER_PW   (4'b1111),
    .MAX_TRIES   (3),
    .OPEN_TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .code_in   (code_in),
    .enter_btn (enter_btn),
    .change_btn(change_btn),
    .lock_btn  (lock_btn),
    .state     (state),
    .unlocked  (unlocked),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk_st(input string tag,
                        input logic [2:0] st,
                        input logic [2:0] fc);
    chk({tag, ".state"}, {5'd0, state}, {5'd0, st});
    chk({tag, ".fail"}, {5'd0, fail_cnt}, {5'd0, fc});
    chk({tag, ".unl"}, {7'd0, unlocked}, {7'd0, st == OP});
    chk({tag, ".alm"}, {7'd0, alarm}, {7'd0, st == AL});
  endtask

  // Event reaches the FSM two edges after first sample; three cycles total.
  task automatic press(input logic e, input logic c,
                       input logic l, input logic [3:0] code);
    @(negedge clk);
    code_in    = code;
    enter_btn  = e;
    change_btn = c;
    lock_btn   = l;
    @(negedge clk);
    @(negedge clk);
    enter_btn  = 1'b0;
    change_btn = 1'b0;
    lock_btn   = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_st("reset", LK, 3'd0);
    resetn = 1'b1;
    @(negedge clk);

    code_in   = 4'b1010;
    enter_btn = 1'b1;
    @(negedge clk);
    chk("lat_n", {5'd0, state}, {5'd0, LK});
    @(negedge clk);
    chk("lat_n1", {5'd0, state}, {5'd0, LK});
    enter_btn = 1'b0;
    @(negedge clk);
    chk_st("lat_n2", OP, 3'd0);

    press(0, 0, 1, 4'd0);
    chk_st("lock0", LK, 3'd0);

    press(1, 0, 0, 4'b0001);
    chk_st("wrong1", RT, 3'd1);
    press(1, 0, 0, 4'b0010);
    chk_st("wrong2", RT, 3'd2);
    press(1, 0, 0, 4'b0011);
    chk_st("wrong3", AL, 3'd3);
    press(1, 0, 0, 4'b1010);
    chk_st("alm_pw", AL, 3'd3);
    press(0, 1, 1, 4'b1111);
    chk_st("alm_btn", AL, 3'd3);
    press(1, 0, 0, 4'b1111);
    chk_st("master", LK, 3'd0);

    press(1, 0, 0, 4'b1010);
    chk_st("open", OP, 3'd0);
    press(1, 0, 0, 4'b0000);
    chk_st("open_ent", OP, 3'd0);
    press(0, 1, 0, 4'd0);
    chk_st("newpw", NP, 3'd0);
    press(1, 0, 0, 4'b0110);
    chk_st("setpw", OP, 3'd0);
    press(0, 0, 1, 4'd0);
    chk_st("lock1", LK, 3'd0);
    press(1, 0, 0, 4'b1010);
    chk_st("oldpw", RT, 3'd1);
    press(1, 0, 0, 4'b0110);
    chk_st("newok", OP, 3'd0);

    press(0, 1, 1, 4'd0);
    chk_st("lk_chg", LK, 3'd0);
    press(1, 0, 0, 4'b0110);
    press(0, 1, 0, 4'd0);
    chk_st("newpw2", NP, 3'd0);
    press(1, 0, 1, 4'b0000);
    chk_st("lk_ent", LK, 3'd0);
    press(1, 0, 0, 4'b0110);
    chk_st("pw_kept", OP, 3'd0);

    press(0, 0, 1, 4'd0);
    @(negedge clk);
    code_in   = 4'b0101;
    enter_btn = 1'b1;
    repeat (20) @(negedge clk);
    enter_btn = 1'b0;
    repeat (2) @(negedge clk);
    chk_st("hold", RT, 3'd1);

    press(1, 0, 0, 4'b0110);
    press(0, 1, 0, 4'd0);
    chk_st("newpw3", NP, 3'd0);
    #1 resetn = 1'b0;
    #1 chk_st("async_rst", LK, 3'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    press(1, 0, 0, 4'b0110);
    chk_st("rst_pw", RT, 3'd1);
    press(1, 0, 0, 4'b1010);
    chk_st("rst_def", OP, 3'd0);
    press(0, 0, 1, 4'd0);

`ifdef AUTO_RELOCK_EN
    @(negedge clk);
    code_in   = 4'b1010;
    enter_btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    enter_btn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("to_open%0d", i), {5'd0, state}, {5'd0, OP});
    end
    @(negedge clk);
    chk_st("to_relock", LK, 3'd0);
`else
    press(1, 0, 0, 4'b1010);
    repeat (100) @(negedge clk);
    chk_st("no_timer", OP, 3'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
